fft_bitrev_reorder: RTL and testbench



---
 rtl/fft_bitrev_reorder_pkg.sv | 22 ++
 rtl/fft_bitrev_reorder_ram_sdp.sv | 27 ++
 rtl/fft_bitrev_reorder.sv | 217 +++++++++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared FFT definitions: sample width, read-side states and the bit-reversal helper.
// bitrev() reverses the low 'bits' bits of idx (bits <= BITREV_MAX_W).
package fft_bitrev_reorder_pkg;

  localparam int FFT_SAMPLE_W = 24;
  localparam int BITREV_MAX_W = 16;

  typedef enum logic {
    RD_IDLE,
    RD_READ
  } rd_state_e;

  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] idx,
                                                     input int bits);
    logic [BITREV_MAX_W-1:0] rev;
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      rev[i] = idx[BITREV_MAX_W-1-i];
    end
    return rev >> (BITREV_MAX_W - bits);
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_ram_sdp.sv
// Simple dual-port RAM: one write port, one read port with a registered (1-cycle) read.
// Read-before-write when both ports hit the same address on the same edge.
module ram_sdp #(
  parameter int DW = 48,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [(1 << AW)];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT bins into natural order through a ping-pong RAM.
// Bin 0 leaves two cycles after a frame's last sample; a 2-entry skid buffer absorbs ready_i stalls.
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int WIDTH = FFT_SAMPLE_W,
  parameter int N     = 1024,
  parameter int LOG2N = 10
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] x_re_i,
  input  logic [WIDTH-1:0] x_im_i,
  output logic [WIDTH-1:0] z_re_o,
  output logic [WIDTH-1:0] z_im_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             last_o,
  output logic [LOG2N-1:0] bin_o,
  output logic             overflow_o
);

  typedef struct packed {
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
    logic [LOG2N-1:0] bin;
    logic             last;
  } out_t;

  localparam logic [LOG2N-1:0] LAST_BIN = LOG2N'(N - 1);

  logic [LOG2N-1:0] wr_cnt;
  logic             wr_bank;
  logic             drop;
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             overflow;
  logic             frame_start;
  logic             drop_now;
  logic             wr_en;
  logic             fill_done;
  logic [LOG2N:0]   wr_addr;

  rd_state_e        state;
  rd_state_e        state_nxt;
  logic             rd_bank;
  logic [LOG2N-1:0] rd_cnt;
  logic             issue;
  logic             rd_last;
  logic             can_issue;
  logic             rd_vld;
  logic [LOG2N-1:0] rd_bin;
  logic [2*WIDTH-1:0] rd_data;

  out_t             head;
  out_t             tail;
  out_t             ram_ent;
  logic [1:0]       occ;
  logic             push;
  logic             pop;

  // A dropped frame still advances wr_cnt so later frames keep their alignment.
  assign frame_start = valid_i && (wr_cnt == '0);
  assign drop_now    = frame_start ? full[wr_bank] : drop;
  assign wr_en       = valid_i && !drop_now;
  assign fill_done   = wr_en && (wr_cnt == LAST_BIN);
  assign wr_addr     = {wr_bank, LOG2N'(bitrev(BITREV_MAX_W'(wr_cnt), LOG2N))};

  // A bank is released once its last address has been read out of the RAM; the
  // remaining bins sit in the output pipeline, so back-to-back frames never collide.
  always_comb begin
    full_nxt = full;
    if (fill_done) begin
      full_nxt[wr_bank] = 1'b1;
    end
    if (rd_last) begin
      full_nxt[rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      wr_cnt   <= '0;
      wr_bank  <= 1'b0;
      drop     <= 1'b0;
      full     <= 2'b00;
      overflow <= 1'b0;
    end else begin
      if (valid_i) begin
        wr_cnt <= wr_cnt + LOG2N'(1);
        if (frame_start) begin
          drop <= full[wr_bank];
        end
      end
      if (frame_start && full[wr_bank]) begin
        overflow <= 1'b1;
      end
      if (fill_done) begin
        wr_bank <= ~wr_bank;
      end
      full <= full_nxt;
    end
  end

  // Issue a read only if the result is guaranteed a skid-buffer slot two cycles on.
  assign pop       = (occ != 2'd0) && ready_i;
  assign push      = rd_vld;
  assign can_issue = (occ + {1'b0, rd_vld} - {1'b0, pop}) < 2'd2;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      RD_IDLE: begin
        if (full[rd_bank] && can_issue) begin
          issue     = 1'b1;
          state_nxt = RD_READ;
        end
      end
      RD_READ: begin
        if (can_issue) begin
          issue = 1'b1;
          if (rd_cnt == LAST_BIN) begin
            state_nxt = RD_IDLE;
          end
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  assign rd_last = issue && (rd_cnt == LAST_BIN);

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state   <= RD_IDLE;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
      rd_vld  <= 1'b0;
      rd_bin  <= '0;
    end else begin
      state  <= state_nxt;
      rd_vld <= issue;
      if (issue) begin
        rd_cnt <= rd_cnt + LOG2N'(1);
        rd_bin <= rd_cnt;
      end
      if (rd_last) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

  ram_sdp #(
    .DW(2 * WIDTH),
    .AW(LOG2N + 1)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data ({x_re_i, x_im_i}),
    .rd_en   (issue),
    .rd_addr ({rd_bank, rd_cnt}),
    .rd_data (rd_data)
  );

  assign ram_ent.re   = rd_data[2*WIDTH-1:WIDTH];
  assign ram_ent.im   = rd_data[WIDTH-1:0];
  assign ram_ent.bin  = rd_bin;
  assign ram_ent.last = (rd_bin == LAST_BIN);

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      head <= '0;
      tail <= '0;
      occ  <= 2'd0;
    end else begin
      case (occ)
        2'd0: begin
          if (push) begin
            head <= ram_ent;
            occ  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= ram_ent;
          end else if (push) begin
            tail <= ram_ent;
            occ  <= 2'd2;
          end else if (pop) begin
            occ <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head <= tail;
            if (push) begin
              tail <= ram_ent;
            end else begin
              occ <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  assign valid_o    = (occ != 2'd0);
  assign z_re_o     = head.re;
  assign z_im_o     = head.im;
  assign bin_o      = head.bin;
  assign last_o     = head.last;
  assign overflow_o = overflow;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder with N=8: ordering, latency, stalls, overflow and reset abort.
module tb_fft_bitrev_reorder;

  localparam int W  = 24;
  localparam int NN = 8;
  localparam int LN = 3;

  logic          clk     = 1'b0;
  logic          srst_n  = 1'b0;
  logic          valid_i = 1'b0;
  logic [W-1:0]  x_re_i  = '0;
  logic [W-1:0]  x_im_i  = '0;
  logic          ready_i = 1'b1;
  logic [W-1:0]  z_re_o;
  logic [W-1:0]  z_im_o;
  logic          valid_o;
  logic          last_o;
  logic [LN-1:0] bin_o;
  logic          overflow_o;

  typedef struct {
    int re;
    int bin;
    bit last;
  } exp_t;

  exp_t        exp_q[$];
  int          br8[NN] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_out = 0;
  int          n_stall = 0;
  int          rdy_mode = 1;
  bit          gap_en = 1'b0;
  bit          in_frame = 1'b0;
  bit          stall_prev = 1'b0;
  logic [63:0] snap = '0;

  fft_bitrev_reorder #(.WIDTH(W), .N(NN), .LOG2N(LN)) dut (
    .clk        (clk),
    .srst_n     (srst_n),
    .valid_i    (valid_i),
    .x_re_i     (x_re_i),
    .x_im_i     (x_im_i),
    .z_re_o     (z_re_o),
    .z_im_o     (z_im_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .last_o     (last_o),
    .bin_o      (bin_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", tag, act, req);
    end
  endtask

  // 0: hold low, 1: hold high, 2: toggle every cycle
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       ready_i = 1'b0;
      1:       ready_i = 1'b1;
      default: ready_i = ~ready_i;
    endcase
  end

  always @(negedge clk) begin
    if (srst_n) begin
      if (stall_prev) begin
        n_stall++;
        chk("stall_hold", {11'b0, valid_o, z_re_o, z_im_o, bin_o, last_o}, snap);
      end
      if (gap_en && in_frame && ready_i) begin
        chk("frame_gap", {63'b0, valid_o}, 64'd1);
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          chk("extra_out", {63'b0, valid_o}, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_re",   {40'b0, z_re_o}, {40'b0, 24'(e.re)});
          chk("out_im",   {40'b0, z_im_o}, {40'b0, 24'(-(e.re + 1))});
          chk("out_bin",  {61'b0, bin_o},  64'(e.bin));
          chk("out_last", {63'b0, last_o}, 64'(e.last));
        end
        n_out++;
        in_frame = !last_o;
      end
      stall_prev = valid_o && !ready_i;
      snap = {11'b0, valid_o, z_re_o, z_im_o, bin_o, last_o};
    end else begin
      stall_prev = 1'b0;
      in_frame   = 1'b0;
    end
  end

  task automatic send(input int v);
    valid_i = 1'b1;
    x_re_i  = 24'(v);
    x_im_i  = 24'(-(v + 1));
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic send_frame(input int f);
    for (int k = 0; k < NN; k++) send(NN * f + k);
  endtask

  task automatic exp_frame(input int f);
    for (int b = 0; b < NN; b++) begin
      exp_t e;
      e.re   = NN * f + br8[b];
      e.bin  = b;
      e.last = (b == NN - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string tag);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 300) begin
      @(posedge clk);
      #1;
      i++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_idle"}, {63'b0, valid_o}, 64'd0);
  endtask

  task automatic chk_latency(input string tag);
    @(negedge clk);
    chk({tag, "_lat_T"}, {63'b0, valid_o}, 64'd0);
    @(negedge clk);
    chk({tag, "_lat_T1"}, {63'b0, valid_o}, 64'd0);
    @(negedge clk);
    chk({tag, "_lat_T2"}, {63'b0, valid_o}, 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual still running, required finished");
    $fatal(1);
  end

  initial begin
    int start;
    int stall0;
    bit found;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {63'b0, valid_o}, 64'd0);
    chk("rst_last",  {63'b0, last_o}, 64'd0);
    chk("rst_bin",   {61'b0, bin_o}, 64'd0);
    chk("rst_ovf",   {63'b0, overflow_o}, 64'd0);
    chk("rst_re",    {40'b0, z_re_o}, 64'd0);
    chk("rst_im",    {40'b0, z_im_o}, 64'd0);
    srst_n = 1'b1;

    // 1: single frame, bitrev order and T+2 latency
    gap_en = 1'b1;
    start  = n_out;
    exp_frame(0);
    send_frame(0);
    chk_latency("t1");
    wait_drain("t1");
    chk("t1_count", 64'(n_out - start), 64'd8);

    // 2: four back-to-back frames
    start = n_out;
    for (int f = 0; f < 4; f++) exp_frame(f);
    for (int f = 0; f < 4; f++) send_frame(f);
    wait_drain("t2");
    chk("t2_count", 64'(n_out - start), 64'd32);
    chk("t2_ovf", {63'b0, overflow_o}, 64'd0);
    gap_en = 1'b0;

    // 3: toggling ready
    rdy_mode = 2;
    stall0   = n_stall;
    exp_frame(0);
    send_frame(0);
    wait_drain("t3");
    chk("t3_stalls_seen", 64'(n_stall > stall0), 64'd1);
    rdy_mode = 1;
    @(posedge clk);
    #1;

    // 4: frame 2 dropped while both banks are held
    rdy_mode = 0;
    exp_frame(0);
    exp_frame(1);
    send_frame(0);
    send_frame(1);
    chk("t4_ovf_before", {63'b0, overflow_o}, 64'd0);
    send(16);
    chk("t4_ovf_set", {63'b0, overflow_o}, 64'd1);
    for (int k = 17; k < 24; k++) send(k);
    rdy_mode = 1;
    wait_drain("t4a");
    repeat (20) @(posedge clk);
    #1;
    exp_frame(3);
    send_frame(3);
    wait_drain("t4b");
    chk("t4_ovf_sticky", {63'b0, overflow_o}, 64'd1);

    // 5: reset while bin 3 is on the output
    exp_frame(0);
    send_frame(0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (valid_o && bin_o == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_bin3_seen", {63'b0, found}, 64'd1);
    srst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_valid_rst", {63'b0, valid_o}, 64'd0);
    chk("t5_ovf_rst",   {63'b0, overflow_o}, 64'd0);
    chk("t5_re_rst",    {40'b0, z_re_o}, 64'd0);
    srst_n = 1'b1;
    exp_q.delete();
    start = n_out;
    exp_frame(0);
    send_frame(0);
    wait_drain("t5");
    chk("t5_count", 64'(n_out - start), 64'd8);

    // 6: valid_i every other cycle
    exp_frame(0);
    for (int k = 0; k < NN; k++) begin
      send(k);
      if (k < NN - 1) begin
        @(posedge clk);
        #1;
      end
    end
    chk_latency("t6");
    wait_drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
